control_sequencer: RTL and testbench
====================================

// Module: control_sequencer
// PURPOSE
//   Producer side of controlpack::control_word_t. Fetches opcode and operand bytes, sequences micro-steps, and emits one
//   control word per cycle to the register file, ALU and memory. Increments the PC itself through INC1 with carry
//   into PC_ADDR_HIGH, and halts on HLT or an illegal opcode. Sits between the memory data bus and the datapath.
// PARAMETERS
//   RESET_CYCLES     2   cycles control_word.reset is held after rst_n deasserts (1..15)
//   HALT_ON_ILLEGAL  1   1: undefined opcode -> S_HALT with illegal_o=1; 0: treated as NOP
// PORTS
//   clk            in   1    system clock, all state on rising edge
//   rst_n          in   1    asynchronous active-low reset
//   ena            in   1    step enable; 0 freezes all state
//   data_i         in   8    memory data bus, valid in the cycle after a READ cycle
//   flags_i        in   2    alu_flag_t, registered by datapath at end of each ALU cycle
//   control_word_o out  21   control_word_t for the current cycle
//   reg_wr_o       out  1    register_op_e: INWRITE commits InxD at cycle end
//   addr_src_o     out  1    address_source_sel_e (always CONTROL_ADDRESS in this block)
//   mem_bus_sel_o  out  1    memory_bus_selector_e (PC for every fetch)
//   halted_o       out  1    in S_HALT
//   illegal_o      out  1    sticky: halted on undefined opcode
// BEHAVIOUR
//   Moore: state, IR, OPR and rst counter are registered; outputs decode from them with no extra latency.
//   IDLE word: ALUNOP, READ, all selectors REG_A, source ALU, all flag bits 0, reg_wr INNOP.
//   Every field not listed for a state takes its IDLE value.
//   Reset (async): state=S_RST, IR=OPR=0, cnt=0, illegal_o=0; outputs = IDLE with .reset=1.
//   ena=0: state, IR, OPR and cnt hold; outputs = IDLE (reset/halt bits still reflect S_RST/S_HALT).
//   States and transitions (each lasts 1 enabled cycle unless noted):
//     S_RST   .reset=1; cnt++; -> S_FETCH when cnt==RESET_CYCLES-1.
//     S_FETCH READ at PC, next_instr=1 -> S_LATCH.
//     S_LATCH IR<=data_i; control_unit_load=1; INC1 Reg1=InxD=PC_ADDR_LOW, source ALU, INWRITE -> S_PCHI.
//     S_PCHI  if flags_i.alu_carry: INC1 Reg1=InxD=PC_ADDR_HIGH, INWRITE, else IDLE. Next state:
//             phase=0: dispatch on IR[7:4]:
//               NOP -> S_FETCH
//               LDX, AOP -> S_OPRD
//               HLT(4'hF) -> S_HALT
//               other -> S_HALT with illegal_o=1 (HALT_ON_ILLEGAL=1), else S_FETCH
//             phase=1: -> S_FETCH.
//     S_OPRD  READ at PC -> S_OPLAT.
//     S_OPLAT OPR<=data_i.
//             LDX: InxD=IR[2:0], source BUS, INWRITE; -> S_PCLO (phase=1).
//             AOP: -> S_EXEC.
//     S_EXEC  alu_op=IR[3:0], Reg1=InxD=OPR[2:0], Reg2=OPR[5:3], source ALU, INWRITE -> S_PCLO (phase=1).
//     S_PCLO  same word as the S_LATCH increment -> S_PCHI.
//     S_HALT  .halt=1, halted_o=1; leaves only via rst_n.
//   Latency, opcode byte to next S_FETCH: NOP 3, LDX 7, AOP 8 enabled cycles.
//   PC wrap: FF:FF + INC1 -> 00:00 (carry on high byte ignored).
//   IR[3:0]=ALUNOP in AOP: executes, and InxD is still written with the ALU result.
//   flags_i is sampled only in S_PCHI; flags present in any other cycle are ignored.
//   Reset mid-instruction abandons the instruction with no partial PC fix-up.
// STRUCTURE
//   Add to controlpack: seq_state_e (S_RST..S_HALT), HLT opcode 4'hF in instructions_e, localparam CW_IDLE.
//   One sub-module: control_word_gen, combinational (state, IR, OPR, flags) -> control word + sideband.
//   Parent module holds state register, IR, OPR, phase and rst counter.
// TESTING
//   1. Reset release, RESET_CYCLES=2 -> .reset=1 for exactly 2 cycles; S_FETCH with READ/PC and next_instr=1 on 3rd.
//   2. Bytes 0x00,0x00 -> two 3-cycle NOP loops; each S_LATCH shows INC1 on PC_ADDR_LOW with INWRITE.
//   3. 0x11 then 0x5A -> S_OPLAT: InxD=REG_B, source BUS, INWRITE; then one PC increment; back at S_FETCH in 7 cycles.
//   4. 0x22 (AOP ADD) then 0x08 -> S_EXEC: alu_op=ADD, Reg1=InxD=REG_A, Reg2=REG_B, INWRITE; 8 cycles total.
//   5. flags_i.alu_carry=1 in S_PCHI -> INC1 on PC_ADDR_HIGH with INWRITE. carry=0 -> IDLE word.
//   6. 0xF0 -> halt=1 held; 0x70 -> halt and illegal_o=1. ena=0 mid-AOP freezes state; rst_n low -> S_RST at once.

Source files
------------

// File: rtl/controlpack.sv
// controlpack: shared control-word, selector and sequencer types for the control path.
// The datapath decodes control_word_t fields directly, so field order is part of the interface.
package controlpack;
    typedef enum logic [3:0] {
        ALUNOP = 4'h0, INC1 = 4'h1, ADD = 4'h2, SUB = 4'h3,
        AND_OP = 4'h4, OR_OP = 4'h5, XOR_OP = 4'h6, DEC1 = 4'h7,
        SHL = 4'h8, SHR = 4'h9, ROL = 4'hA, ROR = 4'hB,
        NOT_OP = 4'hC, CMP = 4'hD, PASS_A = 4'hE, PASS_B = 4'hF
    } alu_op_e;
    typedef enum logic {READ = 1'b0, WRITE = 1'b1} mem_op_e;
    typedef enum logic [2:0] {
        REG_A, REG_B, REG_C, REG_D, REG_E, REG_F, PC_ADDR_LOW, PC_ADDR_HIGH
    } register_sel_e;
    typedef enum logic {SRC_ALU = 1'b0, SRC_BUS = 1'b1} data_source_e;
    typedef enum logic {INNOP = 1'b0, INWRITE = 1'b1} register_op_e;
    typedef enum logic {CONTROL_ADDRESS = 1'b0, DATA_ADDRESS = 1'b1} address_source_sel_e;
    typedef enum logic {MB_PC = 1'b0, MB_DATA = 1'b1} memory_bus_selector_e;
    typedef enum logic [3:0] {NOP = 4'h0, LDX = 4'h1, AOP = 4'h2, HLT = 4'hF} instructions_e;
    typedef enum logic [3:0] {
        S_RST, S_FETCH, S_LATCH, S_PCHI, S_OPRD, S_OPLAT, S_EXEC, S_PCLO, S_HALT
    } seq_state_e;
    typedef struct packed {
        logic alu_carry;
        logic alu_zero;
    } alu_flag_t;
    typedef struct packed {
        alu_op_e       alu_op;
        mem_op_e       mem_op;
        register_sel_e reg1;
        register_sel_e reg2;
        register_sel_e inxd;
        data_source_e  source;
        logic          reset;
        logic          halt;
        logic          next_instr;
        logic          control_unit_load;
        logic          flag_load;
        logic          carry_in;
    } control_word_t;
    localparam control_word_t CW_IDLE = '{
        alu_op: ALUNOP, mem_op: READ, reg1: REG_A, reg2: REG_A, inxd: REG_A, source: SRC_ALU,
        reset: 1'b0, halt: 1'b0, next_instr: 1'b0, control_unit_load: 1'b0,
        flag_load: 1'b0, carry_in: 1'b0
    };
    function automatic control_word_t inc_word(register_sel_e r);
        control_word_t w;
        w = CW_IDLE;
        w.alu_op = INC1;
        w.reg1 = r;
        w.inxd = r;
        return w;
    endfunction
endpackage

// File: rtl/control_sequencer_control_word_gen.sv
// control_word_gen: combinational decode of sequencer state, IR and OPR into the per-cycle control word.
module control_word_gen
    import controlpack::*;
(
    input  seq_state_e    state,
    input  logic          ena,
    input  logic [7:0]    ir,
    input  logic [5:0]    opr,
    input  logic          carry,
    output control_word_t cw,
    output register_op_e  reg_wr
);
    always_comb begin
        cw = CW_IDLE;
        reg_wr = INNOP;
        if (ena) begin
            unique case (state)
                S_FETCH: cw.next_instr = 1'b1;
                S_LATCH: begin
                    cw = inc_word(PC_ADDR_LOW);
                    cw.control_unit_load = 1'b1;
                    reg_wr = INWRITE;
                end
                S_PCHI: if (carry) begin
                    cw = inc_word(PC_ADDR_HIGH);
                    reg_wr = INWRITE;
                end
                S_OPLAT: if (ir[7:4] == LDX) begin
                    cw.inxd = register_sel_e'(ir[2:0]);
                    cw.source = SRC_BUS;
                    reg_wr = INWRITE;
                end
                S_EXEC: begin
                    cw.alu_op = alu_op_e'(ir[3:0]);
                    cw.reg1 = register_sel_e'(opr[2:0]);
                    cw.inxd = register_sel_e'(opr[2:0]);
                    cw.reg2 = register_sel_e'(opr[5:3]);
                    reg_wr = INWRITE;
                end
                S_PCLO: begin
                    cw = inc_word(PC_ADDR_LOW);
                    reg_wr = INWRITE;
                end
                default: ;
            endcase
        end
        // reset/halt reflect the state even while frozen
        cw.reset = (state == S_RST);
        cw.halt = (state == S_HALT);
    end
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: fetch/decode/execute sequencer driving one control word per enabled cycle.
// The PC lives in the register file; this block only issues INC1 steps and follows the carry.
module control_sequencer
    import controlpack::*;
#(
    parameter int RESET_CYCLES    = 2,
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic [7:0]           data_i,
    input  alu_flag_t            flags_i,
    output control_word_t        control_word_o,
    output register_op_e         reg_wr_o,
    output address_source_sel_e  addr_src_o,
    output memory_bus_selector_e mem_bus_sel_o,
    output logic                 halted_o,
    output logic                 illegal_o
);
    seq_state_e state, state_nxt;
    logic [7:0] ir;
    logic [5:0] opr;
    logic [3:0] cnt;
    logic       phase, phase_nxt, illegal_nxt;
    logic       unused_zero;

    assign unused_zero = flags_i.alu_zero;

    always_comb begin
        state_nxt = state;
        phase_nxt = phase;
        illegal_nxt = illegal_o;
        unique case (state)
            S_RST:   state_nxt = (cnt == 4'(RESET_CYCLES - 1)) ? S_FETCH : S_RST;
            S_FETCH: state_nxt = S_LATCH;
            S_LATCH: begin
                state_nxt = S_PCHI;
                phase_nxt = 1'b0;
            end
            S_PCHI: begin
                if (phase) state_nxt = S_FETCH;
                else begin
                    case (ir[7:4])
                        NOP:      state_nxt = S_FETCH;
                        LDX, AOP: state_nxt = S_OPRD;
                        HLT:      state_nxt = S_HALT;
                        default: begin
                            state_nxt = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
                            illegal_nxt = HALT_ON_ILLEGAL;
                        end
                    endcase
                end
            end
            S_OPRD:  state_nxt = S_OPLAT;
            S_OPLAT: begin
                state_nxt = (ir[7:4] == LDX) ? S_PCLO : S_EXEC;
                phase_nxt = 1'b1;
            end
            S_EXEC:  state_nxt = S_PCLO;
            S_PCLO:  state_nxt = S_PCHI;
            default: state_nxt = S_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_RST;
            ir <= '0;
            opr <= '0;
            cnt <= '0;
            phase <= 1'b0;
            illegal_o <= 1'b0;
        end else if (ena) begin
            state <= state_nxt;
            phase <= phase_nxt;
            illegal_o <= illegal_nxt;
            if (state == S_RST) cnt <= cnt + 4'd1;
            if (state == S_LATCH) ir <= data_i;
            if (state == S_OPLAT) opr <= data_i[5:0];
        end
    end

    control_word_gen u_gen (
        .state  (state),
        .ena    (ena),
        .ir     (ir),
        .opr    (opr),
        .carry  (flags_i.alu_carry),
        .cw     (control_word_o),
        .reg_wr (reg_wr_o)
    );

    assign addr_src_o = CONTROL_ADDRESS;
    assign mem_bus_sel_o = MB_PC;
    assign halted_o = (state == S_HALT);
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: randomized instruction-level checks against a PC-tracking reference model.
module tb_control_sequencer;
    import controlpack::*;

    typedef struct packed {
        control_word_t w;
        logic          wr;
        logic [7:0]    d;
        logic          c;
    } step_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ena = 1'b0;
    logic [7:0]    data_i = '0;
    logic [1:0]    flags_i = '0;
    control_word_t cw;
    logic          reg_wr, addr_src, mem_bus_sel, halted, illegal;
    int            errors = 0;
    int            checks = 0;
    logic [15:0]   pc = '0;

    always #5 clk = ~clk;

    control_sequencer #(.RESET_CYCLES(2), .HALT_ON_ILLEGAL(1'b1)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ena            (ena),
        .data_i         (data_i),
        .flags_i        (flags_i),
        .control_word_o (cw),
        .reg_wr_o       (reg_wr),
        .addr_src_o     (addr_src),
        .mem_bus_sel_o  (mem_bus_sel),
        .halted_o       (halted),
        .illegal_o      (illegal)
    );

    function automatic control_word_t w_inc(register_sel_e r);
        control_word_t w;
        w = '0;
        w.alu_op = INC1;
        w.reg1 = r;
        w.inxd = r;
        return w;
    endfunction

    // Expected per-cycle words for one instruction, while the bench plays the datapath's PC.
    task automatic run_instr(input string tag, input logic [7:0] op, input logic [7:0] opr,
                             input int stall_pct, input int cut);
        step_t q[$];
        step_t s;
        logic  cy;
        int    n;
        s = '0; s.w.next_instr = 1'b1; s.d = 8'($urandom); s.c = 1'($urandom);
        q.push_back(s);
        cy = (pc[7:0] == 8'hFF); pc = pc + 16'd1;
        s = '0; s.w = w_inc(PC_ADDR_LOW); s.w.control_unit_load = 1'b1; s.wr = 1'b1;
        s.d = op; s.c = 1'($urandom);
        q.push_back(s);
        s = '0; s.w = cy ? w_inc(PC_ADDR_HIGH) : '0; s.wr = cy; s.d = 8'($urandom); s.c = cy;
        q.push_back(s);
        if (op[7:4] == 4'h1 || op[7:4] == 4'h2) begin
            s = '0; s.d = 8'($urandom); s.c = 1'($urandom);
            q.push_back(s);
            s = '0; s.d = opr; s.c = 1'($urandom);
            if (op[7:4] == 4'h1) begin
                s.w.inxd = register_sel_e'(op[2:0]); s.w.source = SRC_BUS; s.wr = 1'b1;
            end
            q.push_back(s);
            if (op[7:4] == 4'h2) begin
                s = '0; s.w.alu_op = alu_op_e'(op[3:0]);
                s.w.reg1 = register_sel_e'(opr[2:0]); s.w.inxd = register_sel_e'(opr[2:0]);
                s.w.reg2 = register_sel_e'(opr[5:3]); s.wr = 1'b1;
                s.d = 8'($urandom); s.c = 1'($urandom);
                q.push_back(s);
            end
            cy = (pc[7:0] == 8'hFF); pc = pc + 16'd1;
            s = '0; s.w = w_inc(PC_ADDR_LOW); s.wr = 1'b1; s.d = 8'($urandom); s.c = 1'($urandom);
            q.push_back(s);
            s = '0; s.w = cy ? w_inc(PC_ADDR_HIGH) : '0; s.wr = cy; s.d = 8'($urandom); s.c = cy;
            q.push_back(s);
        end
        for (int i = 0; i < q.size() && i != cut; i++) begin
            n = ($urandom_range(99) < stall_pct) ? int'($urandom_range(1, 3)) : 0;
            repeat (n) begin
                @(negedge clk); ena = 1'b0; data_i = 8'($urandom); flags_i = 2'($urandom); #1;
                checks++;
                if (cw !== control_word_t'('0) || reg_wr !== 1'b0) begin
                    errors++;
                    $display("FAIL %s stall before step %0d: got word %h wr %b, want word 0 wr 0",
                             tag, i, cw, reg_wr);
                end
            end
            @(negedge clk); ena = 1'b1; data_i = q[i].d; flags_i = {q[i].c, 1'($urandom)}; #1;
            checks++;
            if (cw !== q[i].w) begin
                errors++;
                $display("FAIL %s step %0d word: got %h want %h", tag, i, cw, q[i].w);
            end
            checks++;
            if (reg_wr !== q[i].wr || halted !== 1'b0) begin
                errors++;
                $display("FAIL %s step %0d wr/halted: got %b/%b want %b/0", tag, i, reg_wr, halted, q[i].wr);
            end
        end
    endtask

    task automatic test_reset(input string tag);
        control_word_t rw;
        rw = '0; rw.reset = 1'b1;
        @(negedge clk); rst_n = 1'b0; ena = 1'b1; #1;
        checks++;
        if (cw !== rw || reg_wr !== 1'b0 || halted !== 1'b0 || illegal !== 1'b0
            || addr_src !== 1'b0 || mem_bus_sel !== 1'b0) begin
            errors++;
            $display("FAIL %s in reset: got word %h wr %b halted %b illegal %b asrc %b mbus %b, want %h 0 0 0 0 0",
                     tag, cw, reg_wr, halted, illegal, addr_src, mem_bus_sel, rw);
        end
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            checks++;
            if (cw !== rw || halted !== 1'b0) begin
                errors++;
                $display("FAIL %s release cycle %0d: got word %h halted %b want %h 0", tag, i, cw, halted, rw);
            end
        end
        pc = '0;
    endtask

    task automatic test_nop();
        run_instr("nop1", 8'h00, 8'h00, 0, -1);
        run_instr("nop2", 8'h00, 8'h00, 0, -1);
    endtask

    task automatic test_ldx();
        run_instr("ldx", 8'h11, 8'h5A, 0, -1);
    endtask

    task automatic test_aop();
        run_instr("aop_add", 8'h22, 8'h08, 0, -1);
        run_instr("aop_alunop", 8'h20, 8'h3F, 0, -1);
    endtask

    task automatic test_carry();
        pc = 16'h01FF; run_instr("carry_nop", 8'h00, 8'h00, 0, -1);
        pc = 16'h00FE; run_instr("carry_ldx", 8'h13, 8'hC4, 0, -1);
        pc = 16'hFFFF; run_instr("wrap_aop", 8'h25, 8'h2D, 0, -1);
    endtask

    task automatic test_random();
        logic [7:0] op;
        for (int k = 0; k < 40; k++) begin
            op = {4'($urandom_range(2)), 4'($urandom)};
            if ($urandom_range(3) == 0) pc = {8'($urandom), 7'h7F, 1'($urandom)};
            run_instr("random", op, 8'($urandom), 20, -1);
        end
    endtask

    task automatic test_ena_freeze();
        run_instr("freeze_aop", 8'h23, 8'h11, 70, -1);
        run_instr("freeze_ldx", 8'h16, 8'h99, 70, -1);
    endtask

    task automatic test_async_reset();
        control_word_t rw;
        rw = '0; rw.reset = 1'b1;
        run_instr("abort", 8'h22, 8'h08, 0, 4);
        @(posedge clk); #2; rst_n = 1'b0; #1;
        checks++;
        if (cw !== rw || reg_wr !== 1'b0) begin
            errors++;
            $display("FAIL async_reset immediate: got word %h wr %b want %h 0", cw, reg_wr, rw);
        end
        test_reset("post_abort");
        run_instr("after_abort", 8'h00, 8'h00, 0, -1);
    endtask

    task automatic test_halt(input string tag, input logic [7:0] op, input logic exp_ill);
        control_word_t hw;
        hw = '0; hw.halt = 1'b1;
        test_reset({tag, "_reset"});
        run_instr(tag, op, 8'h00, 0, -1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); ena = 1'($urandom); data_i = 8'($urandom); flags_i = 2'($urandom); #1;
            checks++;
            if (cw !== hw || reg_wr !== 1'b0 || halted !== 1'b1 || illegal !== exp_ill) begin
                errors++;
                $display("FAIL %s hold %0d: got word %h wr %b halted %b illegal %b, want %h 0 1 %b",
                         tag, i, cw, reg_wr, halted, illegal, hw, exp_ill);
            end
        end
    endtask

    initial begin
        test_reset("por");
        test_nop();
        test_ldx();
        test_aop();
        test_carry();
        test_random();
        test_ena_freeze();
        test_async_reset();
        test_halt("hlt", 8'hF0, 1'b0);
        test_halt("illegal", 8'h70, 1'b1);
        test_reset("clear_illegal");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
